// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 core: memory access sizes,
// load/store unit FSM states and the default bus response timeout.
package riscv_pkg;

    localparam int XLEN                = 32;
    localparam int LSU_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP
    } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering for a 32-bit data bus: byte enables and
// lane-replicated store data on the way out, lane extraction plus sign or
// zero extension of load data on the way back. Size 2'b11 behaves as word.
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_offset,
    input  logic            i_sign_ext,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Select enables, replicate store data and extend the addressed load lane
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
        case (i_size)
            MEM_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {(XLEN/8){i_wdata[7:0]}};
                o_rdata = {{(XLEN-8){i_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
            end
            MEM_HALF: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {(XLEN/16){i_wdata[15:0]}};
                o_rdata = {{(XLEN-16){i_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer between the single-cycle datapath and a
// request/grant/response data bus. One transaction at a time; the core is
// stalled until the response (or a timeout) retires the access.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_read_en_i,
    input  logic            mem_write_en_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_sign_ext_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            bus_err_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i,
    input  logic            data_err_i
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      r_state;
    lsu_state_e      w_next;
    logic [CW-1:0]   r_count;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [1:0]      r_size;
    logic            r_sign_ext;
    logic [1:0]      r_offset;

    logic            w_access;
    logic            w_misaligned;
    logic            w_idle;
    logic            w_capture;
    logic            w_timeout;
    logic [1:0]      w_al_size;
    logic [1:0]      w_al_offset;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_load_data;

    assign w_access    = mem_read_en_i | mem_write_en_i;
    assign w_idle      = (r_state == LSU_IDLE);
    assign w_timeout   = (r_count == TMAX);
    assign w_al_size   = w_idle ? mem_size_i : r_size;
    assign w_al_offset = w_idle ? addr_i[1:0] : r_offset;

    // Byte accesses are always aligned; halves need bit 0 clear, words both bits
    always_comb begin
        case (mem_size_i)
            MEM_BYTE: w_misaligned = 1'b0;
            MEM_HALF: w_misaligned = addr_i[0];
            default:  w_misaligned = (addr_i[1:0] != 2'b00);
        endcase
    end

    // In IDLE the aligner sees the live request; afterwards the captured access
    lsu_data_align u_align (
        .i_size     (w_al_size),
        .i_offset   (w_al_offset),
        .i_sign_ext (r_sign_ext),
        .i_wdata    (wdata_i),
        .i_rdata    (data_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata_rep),
        .o_rdata    (w_load_data)
    );

    // Next-state and output decode; everything is forced low while in reset
    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        rdata_o      = '0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (rst_ni) begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_access) begin
                        if (w_misaligned) begin
                            misaligned_o = 1'b1;
                        end else begin
                            data_req_o   = 1'b1;
                            stall_o      = 1'b1;
                            data_we_o    = mem_write_en_i;
                            data_be_o    = w_be;
                            data_addr_o  = {addr_i[XLEN-1:2], 2'b00};
                            data_wdata_o = w_wdata_rep;
                            w_capture    = 1'b1;
                            w_next       = data_gnt_i ? LSU_WAIT_RSP : LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (w_timeout) begin
                        bus_err_o = 1'b1;
                        done_o    = 1'b1;
                        w_next    = LSU_IDLE;
                    end else begin
                        data_req_o   = 1'b1;
                        stall_o      = 1'b1;
                        data_we_o    = r_we;
                        data_be_o    = r_be;
                        data_addr_o  = r_addr;
                        data_wdata_o = r_wdata;
                        if (data_gnt_i) begin
                            w_next = LSU_WAIT_RSP;
                        end
                    end
                end
                LSU_WAIT_RSP: begin
                    if (data_rvalid_i) begin
                        done_o = 1'b1;
                        w_next = LSU_IDLE;
                        if (data_err_i) begin
                            bus_err_o = 1'b1;
                        end else if (!r_we) begin
                            rdata_o = w_load_data;
                        end
                    end else if (w_timeout) begin
                        bus_err_o = 1'b1;
                        done_o    = 1'b1;
                        w_next    = LSU_IDLE;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: w_next = LSU_IDLE;
            endcase
        end
    end

    // State register, access capture and timeout counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= LSU_IDLE;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_be       <= 4'b0000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_offset   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_idle) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
            if (w_capture) begin
                r_we       <= mem_write_en_i;
                r_be       <= w_be;
                r_addr     <= {addr_i[XLEN-1:2], 2'b00};
                r_wdata    <= w_wdata_rep;
                r_size     <= mem_size_i;
                r_sign_ext <= mem_sign_ext_i;
                r_offset   <= addr_i[1:0];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: drives accesses against a scripted
// bus, queues the expected retirement result per access and compares it when
// done_o fires. Built with an 8-cycle timeout to keep the timeout case short.
module tb_load_store_unit;

    localparam int TMO = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        memReadEn;
    logic        memWriteEn;
    logic [1:0]  memSize;
    logic        signExt;
    logic [31:0] addrIn;
    logic [31:0] wdataIn;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        busErr;
    logic        dataReq;
    logic        dataGnt;
    logic        dataWe;
    logic [3:0]  dataBe;
    logic [31:0] dataAddr;
    logic [31:0] dataWdata;
    logic        dataRvalid;
    logic [31:0] dataRdata;
    logic        dataErr;

    int   checkCount = 0;
    int   errCount   = 0;
    exp_t expQ[$];

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .mem_read_en_i  (memReadEn),
        .mem_write_en_i (memWriteEn),
        .mem_size_i     (memSize),
        .mem_sign_ext_i (signExt),
        .addr_i         (addrIn),
        .wdata_i        (wdataIn),
        .stall_o        (stall),
        .done_o         (done),
        .rdata_o        (rdata),
        .misaligned_o   (misaligned),
        .bus_err_o      (busErr),
        .data_req_o     (dataReq),
        .data_gnt_i     (dataGnt),
        .data_we_o      (dataWe),
        .data_be_o      (dataBe),
        .data_addr_o    (dataAddr),
        .data_wdata_o   (dataWdata),
        .data_rvalid_i  (dataRvalid),
        .data_rdata_i   (dataRdata),
        .data_err_i     (dataErr)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Scoreboard: every retirement pops the oldest expectation
    always @(negedge clk) begin
        if (rstN && done) begin
            if (expQ.size() == 0) begin
                checkOutput("sb:unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb:rdata", rdata, e.rdata);
                checkOutput("sb:bus_err", 32'(busErr), 32'(e.err));
            end
        end
    end

    // Reference load extraction written independently of the DUT's shifter
    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sext,
                                              input logic [1:0] off, input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = off[1] ? raw[31:16] : raw[15:0];
        if (size == 2'b00)      return sext ? {{24{b[7]}}, b} : {24'd0, b};
        else if (size == 2'b01) return sext ? {{16{h[15]}}, h} : {16'd0, h};
        else                    return raw;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b00)      return 4'b0001 << off;
        else if (size == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        else                    return 4'b1111;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One aligned access: request with a grant delay, response after rspDelay
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic sext,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int gntDelay, input int rspDelay,
                                 input logic [31:0] busRdata, input logic busErrIn,
                                 input logic [3:0] expBe, input logic [31:0] expWdata,
                                 input logic [31:0] expRdata);
        int          stallCycles;
        logic [31:0] expAddr;
        exp_t        e;
        expAddr     = {addr[31:2], 2'b00};
        stallCycles = 0;
        memReadEn   = rd;
        memWriteEn  = wr;
        memSize     = size;
        signExt     = sext;
        addrIn      = addr;
        wdataIn     = wdata;
        dataGnt     = (gntDelay == 0);
        e.rdata     = expRdata;
        e.err       = busErrIn;
        expQ.push_back(e);
        @(negedge clk);
        checkOutput({tag, ":req"}, 32'(dataReq), 32'd1);
        checkOutput({tag, ":we"}, 32'(dataWe), 32'(wr));
        checkOutput({tag, ":be"}, 32'(dataBe), 32'(expBe));
        checkOutput({tag, ":addr"}, dataAddr, expAddr);
        checkOutput({tag, ":wdata"}, dataWdata, expWdata);
        if (stall) stallCycles++;
        for (int k = 1; k <= gntDelay; k++) begin
            nextCycle();
            memReadEn  = 1'b0;
            memWriteEn = 1'b0;
            memSize    = 2'($urandom);
            addrIn     = $urandom;
            wdataIn    = $urandom;
            dataGnt    = (k == gntDelay);
            @(negedge clk);
            checkOutput({tag, ":req_held"}, 32'(dataReq), 32'd1);
            checkOutput({tag, ":be_held"}, 32'(dataBe), 32'(expBe));
            checkOutput({tag, ":addr_held"}, dataAddr, expAddr);
            checkOutput({tag, ":wdata_held"}, dataWdata, expWdata);
            if (stall) stallCycles++;
        end
        nextCycle();
        memReadEn  = 1'b0;
        memWriteEn = 1'b0;
        dataGnt    = 1'b0;
        for (int k = 0; k < rspDelay; k++) begin
            @(negedge clk);
            checkOutput({tag, ":req_wait"}, 32'(dataReq), 32'd0);
            if (stall) stallCycles++;
            nextCycle();
        end
        dataRvalid = 1'b1;
        dataRdata  = busRdata;
        dataErr    = busErrIn;
        @(negedge clk);
        checkOutput({tag, ":done"}, 32'(done), 32'd1);
        checkOutput({tag, ":stall_rsp"}, 32'(stall), 32'd0);
        nextCycle();
        dataRvalid = 1'b0;
        dataErr    = 1'b0;
        dataRdata  = $urandom;
        checkOutput({tag, ":stall_cycles"}, 32'(stallCycles), 32'(1 + gntDelay + rspDelay));
    endtask

    // Misaligned request: pulse only, no bus activity, no stall
    task automatic applyMisaligned(input string tag, input logic rd, input logic wr,
                                   input logic [1:0] size, input logic [31:0] addr);
        memReadEn  = rd;
        memWriteEn = wr;
        memSize    = size;
        addrIn     = addr;
        dataGnt    = 1'b1;
        @(negedge clk);
        checkOutput({tag, ":misaligned"}, 32'(misaligned), 32'd1);
        checkOutput({tag, ":req"}, 32'(dataReq), 32'd0);
        checkOutput({tag, ":stall"}, 32'(stall), 32'd0);
        checkOutput({tag, ":done"}, 32'(done), 32'd0);
        nextCycle();
        memReadEn  = 1'b0;
        memWriteEn = 1'b0;
        dataGnt    = 1'b0;
        @(negedge clk);
        checkOutput({tag, ":idle_after"}, {29'd0, misaligned, dataReq, stall}, 32'd0);
        nextCycle();
    endtask

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [1:0]  sz;
        logic [1:0]  off;
        logic        sx;
        logic [31:0] raw;
        rstN       = 1'b0;
        memReadEn  = 1'b1;
        memWriteEn = 1'b0;
        memSize    = 2'b10;
        signExt    = 1'b0;
        addrIn     = 32'h100;
        wdataIn    = 32'h0;
        dataGnt    = 1'b1;
        dataRvalid = 1'b0;
        dataRdata  = 32'h0;
        dataErr    = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("reset:outputs", {27'd0, stall, done, misaligned, busErr, dataReq}, 32'd0);
        checkOutput("reset:addr", dataAddr, 32'd0);
        nextCycle();
        rstN      = 1'b1;
        memReadEn = 1'b0;
        dataGnt   = 1'b0;
        nextCycle();

        $display("[TB] directed accesses");
        applyStimulus("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
        applyStimulus("lb", 1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 0, 32'h80112233, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
        applyStimulus("lbu", 1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 0, 32'h80112233, 0, 4'b1000, 32'h0, 32'h00000080);
        applyStimulus("sh", 0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 3, 0, 32'h12345678, 0, 4'b1100, 32'hABCDABCD, 32'h0);
        applyStimulus("sb", 0, 1, 2'b00, 0, 32'h3, 32'h0000005A, 1, 2, 32'h0, 0, 4'b1000, 32'h5A5A5A5A, 32'h0);
        applyStimulus("lh", 1, 0, 2'b01, 1, 32'h106, 32'h0, 0, 1, 32'h80010000, 0, 4'b1100, 32'h0, 32'hFFFF8001);
        applyStimulus("lw11", 1, 0, 2'b11, 0, 32'h108, 32'h0, 0, 0, 32'h0BADF00D, 0, 4'b1111, 32'h0, 32'h0BADF00D);
        applyStimulus("err", 1, 0, 2'b10, 0, 32'h500, 32'h0, 0, 0, 32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'h0);
        applyStimulus("rdwr", 1, 1, 2'b10, 0, 32'h600, 32'h11223344, 0, 0, 32'h55667788, 0, 4'b1111, 32'h11223344, 32'h0);

        $display("[TB] misaligned accesses");
        applyMisaligned("mis_lw", 1, 0, 2'b10, 32'h101);
        applyMisaligned("mis_sh", 0, 1, 2'b01, 32'h203);
        applyMisaligned("mis_lw11", 1, 0, 2'b11, 32'h102);

        $display("[TB] stray grant and response in IDLE");
        dataGnt    = 1'b1;
        dataRvalid = 1'b1;
        @(negedge clk);
        checkOutput("stray:outputs", {27'd0, stall, done, misaligned, busErr, dataReq}, 32'd0);
        nextCycle();
        dataGnt    = 1'b0;
        dataRvalid = 1'b0;

        $display("[TB] random aligned loads");
        for (int i = 0; i < 12; i++) begin
            sz  = 2'($urandom_range(0, 2));
            sx  = 1'($urandom);
            raw = $urandom;
            off = 2'($urandom);
            if (sz == 2'b01) off[0] = 1'b0;
            if (sz == 2'b10) off = 2'b00;
            applyStimulus("rnd", 1, 0, sz, sx, {24'h000C00, 6'($urandom), off}, 32'h0,
                          $urandom_range(0, 2), $urandom_range(0, 2), raw, 0,
                          modelBe(sz, off), 32'h0, modelLoad(sz, sx, off, raw));
        end

        $display("[TB] response timeout");
        begin
            exp_t e;
            memReadEn = 1'b1;
            memSize   = 2'b10;
            addrIn    = 32'h400;
            dataGnt   = 1'b1;
            e.rdata   = 32'h0;
            e.err     = 1'b1;
            expQ.push_back(e);
            @(negedge clk);
            checkOutput("tmo:req", 32'(dataReq), 32'd1);
            for (int k = 1; k < TMO; k++) begin
                nextCycle();
                memReadEn = 1'b0;
                dataGnt   = 1'b0;
                @(negedge clk);
                checkOutput("tmo:waiting", {30'd0, stall, done}, 32'd2);
            end
            nextCycle();
            @(negedge clk);
            checkOutput("tmo:fire", {28'd0, busErr, done, stall, dataReq}, 32'b1100);
            nextCycle();
            dataRvalid = 1'b1;
            dataRdata  = 32'hFFFFFFFF;
            @(negedge clk);
            checkOutput("tmo:late_rvalid", {29'd0, busErr, done, stall}, 32'd0);
            nextCycle();
            dataRvalid = 1'b0;
        end

        $display("[TB] reset during WAIT_RSP");
        memReadEn = 1'b1;
        memSize   = 2'b10;
        addrIn    = 32'h700;
        dataGnt   = 1'b1;
        @(negedge clk);
        checkOutput("rst:req", 32'(dataReq), 32'd1);
        nextCycle();
        memReadEn  = 1'b0;
        dataGnt    = 1'b0;
        rstN       = 1'b0;
        dataRvalid = 1'b1;
        dataRdata  = 32'h11111111;
        @(negedge clk);
        checkOutput("rst:in_reset", {29'd0, done, stall, busErr}, 32'd0);
        nextCycle();
        rstN       = 1'b1;
        dataRvalid = 1'b0;
        @(negedge clk);
        checkOutput("rst:after", {29'd0, dataReq, stall, done}, 32'd0);
        nextCycle();
        applyStimulus("post_rst", 1, 0, 2'b10, 0, 32'h704, 32'h0, 0, 0, 32'h13579BDF, 0, 4'b1111, 32'h0, 32'h13579BDF);

        checkOutput("sb:leftover", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle sequencer between the single-cycle datapath and a request/grant/response data bus.
- Consumes the decoded memory controls: read/write enable, size, sign-extend.
- Consumes the ALU-computed address and rs2 store data.
- Issues one bus transaction per load/store and stalls the core until the response returns.
- Flags misaligned accesses, bus errors and response timeouts.
- Returns the aligned, extended load data for write-back.

Parameters:
XLEN, 32, data/address width (taken from riscv_pkg).
TIMEOUT_CYCLES, 64, cycles in REQ+WAIT_RSP before a timeout error is raised; must be >=2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
mem_read_en_i  in  1  load request from the control unit
mem_write_en_i  in  1  store request from the control unit
mem_size_i  in  2  00 byte, 01 half, 10 word; 11 decoded as word
mem_sign_ext_i  in  1  1 = sign-extend load, 0 = zero-extend
addr_i  in  XLEN  effective byte address (ALU result)
wdata_i  in  XLEN  store data (rs2)
stall_o  out  1  hold PC and register-file write
done_o  out  1  access retired this cycle
rdata_o  out  XLEN  aligned/extended load data, valid when done_o & load
misaligned_o  out  1  1-cycle pulse: misaligned access, no bus request issued
bus_err_o  out  1  1-cycle pulse: data_err_i or timeout
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_we_o  out  1  1 = write
data_be_o  out  4  byte enables
data_addr_o  out  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}
data_wdata_o  out  XLEN  lane-replicated store data
data_rvalid_i  in  1  response valid (every transaction, loads and stores)
data_rdata_i  in  XLEN  response data
data_err_i  in  1  response error, qualified by data_rvalid_i

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates on rising clk_i.
  - While rst_ni=0: state<=IDLE, timeout counter<=0, captured regs<=0, all outputs 0.
- access = mem_read_en_i | mem_write_en_i.
  - If both are asserted, the write wins and the read is ignored.
- Alignment rules
  - Half is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Byte is never misaligned.
- Byte enables and store data
  - data_be_o: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - data_wdata_o: byte replicated x4; half replicated x2; word passed through.
- Load data
  - rdata_o = (data_rdata_i >> 8*offset), masked to size, then sign- or zero-extended.
  - rdata_o is 0 when not done_o & load.
- IDLE
  - No access: all outputs 0.
  - Misaligned access: misaligned_o=1, stall_o=0, done_o=0, data_req_o=0; stay in IDLE. The core suppresses the writeback/store.
  - Aligned access: data_req_o=1 combinationally from the inputs, stall_o=1.
    - Capture we, be, addr, wdata, size, sign_ext and offset.
    - If data_gnt_i, go to WAIT_RSP; otherwise go to REQ.
- REQ
  - data_req_o=1, driven from the captured regs (stable until grant); stall_o=1.
  - On data_gnt_i, go to WAIT_RSP.
- WAIT_RSP
  - data_req_o=0; stall_o=1 until data_rvalid_i.
  - On data_rvalid_i: stall_o=0 and done_o=1 that cycle.
    - Load: rdata_o is formed combinationally from data_rdata_i using the captured offset, size and sign_ext.
    - If data_err_i=1: bus_err_o=1 and rdata_o=0.
    - Return to IDLE.
  - The core commits in the done cycle. The next instruction's access is sampled no earlier than the following cycle; the core guarantees a new instruction on the next edge.
- Timing
  - Minimum latency (grant in the IDLE cycle, rvalid one cycle later): 2 cycles, 1 stall cycle.
  - data_rvalid_i is never consumed in the same cycle as its grant.
- Timeout
  - Counter clears on leaving IDLE and increments each cycle in REQ/WAIT_RSP.
  - When count == TIMEOUT_CYCLES-1 and no response arrives that cycle:
    - bus_err_o=1, done_o=1, stall_o=0, data_req_o=0 that cycle.
    - Return to IDLE.
  - A late data_rvalid_i arriving in IDLE is ignored.
- Stray inputs
  - data_gnt_i outside a request and data_rvalid_i outside WAIT_RSP are ignored.
- Reset mid-operation: aborts to IDLE; the outstanding response is discarded.
- At most one outstanding transaction, ever.

Decomposition:
- riscv_pkg additions:
  - mem_size_e (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10)
  - lsu_state_e (LSU_IDLE, LSU_REQ, LSU_WAIT_RSP)
  - LSU_TIMEOUT_DEFAULT=64
- Sub-module lsu_data_align: purely combinational.
  - Generates be and replicated wdata from size/offset.
  - Extracts and extends load data.
  - Reusable by a later cached/pipelined core.
- FSM, captured regs and timeout counter stay in load_store_unit.

Test Plan:
- LW addr=0x100, gnt in IDLE cycle, rvalid next cycle with rdata=0xDEADBEEF
  -> data_be_o=1111, data_addr_o=0x100, stall_o=1 for exactly 1 cycle, done_o with rdata_o=0xDEADBEEF.
- LB addr=0x103, sign_ext=1, rdata=0x80112233 -> be=1000, rdata_o=0xFFFFFF80.
- Same access with LBU -> rdata_o=0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, gnt delayed 3 cycles
  -> data_req_o held 4 cycles with be=1100, wdata=0xABCDABCD and addr stable; done_o on rvalid.
- LW addr=0x101 -> misaligned_o=1, data_req_o=0, stall_o=0, state stays IDLE.
- SH addr=0x203 -> same response.
- SB addr=0x3: be=1000.
- Granted load, rvalid never arrives, TIMEOUT_CYCLES=8
  -> bus_err_o and done_o pulse 8 cycles after the request cycle.
  -> A later rvalid in IDLE is ignored.
- rvalid with data_err_i=1 -> bus_err_o=1, rdata_o=0.
- rst_ni=0 asserted in WAIT_RSP -> next cycle data_req_o=0, stall_o=0, and a response arriving in the reset cycle is discarded.
